// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Pipeline hazard unit with a long-latency write scoreboard.
//               Produces E/M/D forwarding selects, load-use and scoreboard
//               stalls, and fetch/decode stall and flush controls. Tracks
//               outstanding MUL/DIV destinations in a pending bit vector.
//               Optional macro HAZARD_SCOREBOARD_WAW_EN adds WAW stalls on
//               D-stage writers whose destination is still pending.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_AW      = 5,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 3
) (
    input  logic              CLK,
    input  logic              RESETn,
    // decode stage
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rdD,
    input  logic [6:0]        OpcodeD,
    input  logic              LongOpD,
    // execute stage
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic              MemtoRegE,
    input  logic              LongIssueE,
    input  logic [1:0]        PCSrcE,
    // memory / writeback stages
    input  logic [REG_AW-1:0] rs2M,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegW,
    input  logic              LongDoneW,
    input  logic [REG_AW-1:0] LongRdW,
    input  logic              Busy,
    // outputs
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              ForwardM,
    output logic              Forward1D,
    output logic              Forward2D,
    output logic              lwStall,
    output logic              ScbStall,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic              FlushD,
    output logic [CNT_W-1:0]  PendingCount,
    output logic              ScbError
);

    localparam int         NREG     = 1 << REG_AW;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BRANCH= 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NREG-1:0]  pending;
    logic [NREG-1:0]  pending_nxt;
    logic [CNT_W-1:0] count_nxt;

    logic rs1_active;
    logic rs2_active;
    logic raw1;
    logic raw2;
    logic waw;
    logic cap_stall;
    logic full;
    logic issue_req;
    logic done_ok;
    logic issue_ok;
    logic set_error;
    logic unused_pcsrc;

    // Only bit 0 of PCSrcE signals a taken redirect.
    assign unused_pcsrc = PCSrcE[1];

    // Source operand usage from the D-stage opcode.
    assign rs1_active = !((OpcodeD == OP_JAL) || (OpcodeD == OP_LUI) || (OpcodeD == OP_AUIPC));
    assign rs2_active = (OpcodeD == OP_RTYPE) || (OpcodeD == OP_BRANCH);

    // E-stage operand forwarding: memory stage takes priority over writeback.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if ((rs1E == rdM) && RegWriteM && (rdM != '0))
            ForwardAE = 2'b10;
        else if ((rs1E == rdW) && RegWriteW && (rdW != '0))
            ForwardAE = 2'b01;
        if ((rs2E == rdM) && RegWriteM && (rdM != '0))
            ForwardBE = 2'b10;
        else if ((rs2E == rdW) && RegWriteW && (rdW != '0))
            ForwardBE = 2'b01;
    end

    assign ForwardM  = (rs2M == rdW) && MemWriteM && MemtoRegW && (rdW != '0);
    assign Forward1D = (rs1D == rdW) && RegWriteW && (rdW != '0);
    assign Forward2D = (rs2D == rdW) && RegWriteW && (rdW != '0);

    assign lwStall = MemtoRegE && (rdE != '0) &&
                     (((rs1D == rdE) && rs1_active) || ((rs2D == rdE) && rs2_active));

    // RAW against pending long writes; a completing write is forwarded
    // through the W->D path so it does not stall.
    assign raw1 = rs1_active && (rs1D != '0) &&
                  ((pending[rs1D] && !(LongDoneW && (LongRdW == rs1D))) ||
                   (LongIssueE && (rdE != '0) && (rs1D == rdE)));
    assign raw2 = rs2_active && (rs2D != '0) &&
                  ((pending[rs2D] && !(LongDoneW && (LongRdW == rs2D))) ||
                   (LongIssueE && (rdE != '0) && (rs2D == rdE)));

    assign full      = (PendingCount == CNT_MAX);
    assign cap_stall = LongOpD && full && !LongDoneW;

`ifdef HAZARD_SCOREBOARD_WAW_EN
    logic rd_writes;
    // Stores and branches are the only opcodes that never write rd.
    assign rd_writes = !((OpcodeD == 7'b0100011) || (OpcodeD == OP_BRANCH));
    assign waw       = rd_writes && (rdD != '0) && pending[rdD] &&
                       !(LongDoneW && (LongRdW == rdD));
`else
    logic unused_rdd;
    assign unused_rdd = ^rdD;
    assign waw        = 1'b0;
`endif

    assign ScbStall = raw1 || raw2 || waw || cap_stall;
    assign StallF   = lwStall || ScbStall || Busy;
    assign StallD   = lwStall || ScbStall || Busy;
    assign FlushE   = lwStall || ScbStall || PCSrcE[0];
    assign FlushD   = PCSrcE[0];

    // A completion is legal only for a tracked destination; a full
    // scoreboard accepts a new issue only when a legal completion frees a slot.
    assign done_ok   = LongDoneW && pending[LongRdW] && (PendingCount != '0);
    assign issue_req = LongIssueE && (rdE != '0);
    assign issue_ok  = issue_req && (!full || done_ok);
    assign set_error = (LongDoneW && !done_ok) || (issue_req && !issue_ok);

    // Next scoreboard state: clear the completing bit first so that an issue
    // to the same register in the same cycle keeps it set.
    always_comb begin
        pending_nxt = pending;
        count_nxt   = PendingCount;
        if (done_ok)
            pending_nxt[LongRdW] = 1'b0;
        if (issue_ok)
            pending_nxt[rdE] = 1'b1;
        case ({issue_ok, done_ok})
            2'b10:   count_nxt = PendingCount + CNT_ONE;
            2'b01:   count_nxt = PendingCount - CNT_ONE;
            default: count_nxt = PendingCount;
        endcase
    end

    // Scoreboard registers with synchronous active-low reset; error is sticky.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            pending      <= '0;
            PendingCount <= '0;
            ScbError     <= 1'b0;
        end else begin
            pending      <= pending_nxt;
            PendingCount <= count_nxt;
            if (set_error)
                ScbError <= 1'b1;
        end
    end

endmodule
`default_nettype wire
